// File: rtl/uart_cfg_pkg.sv
// Shared definitions for the UART config frame: header bytes, frame length,
// parity and stop codes, and the framer state encoding.
package uart_cfg_pkg;

   localparam logic [7:0] HDR0      = 8'hEE;
   localparam logic [7:0] HDR1      = 8'hDD;
   localparam logic [7:0] HDR2      = 8'hCC;
   localparam int         FRAME_LEN = 9;

   localparam logic [7:0] PAR_ODD   = 8'h00;
   localparam logic [7:0] PAR_EVEN  = 8'h01;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP,
      DONE
   } state_t;

   // The stop field counts down while the wire code counts up.
   function automatic logic [7:0] stop_code(input logic [1:0] field);
      logic [7:0] code;
      case (field)
         2'b11:   code = 8'h01;
         2'b10:   code = 8'h02;
         2'b01:   code = 8'h03;
         default: code = 8'h04;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/uart_config_framer.sv
// Serializes a parity/stop/interval configuration into the 9-byte config frame
// on a valid/ready byte stream, with optional idle cycles between bytes.
module uart_config_framer
   import uart_cfg_pkg::*;
#(
   parameter int GAP_CYCLES = 0,
   parameter int GAP_W      = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        parity_in,
   input  logic [1:0]  stopbit_in,
   input  logic [31:0] interval_in,
   output logic [7:0]  dout,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic        busy,
   output logic        done
);

   localparam logic [3:0]       LAST_IDX = 4'(FRAME_LEN - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

   state_t            state, state_next;
   logic [3:0]        idx;
   logic [GAP_W-1:0]  gap_cnt;
   logic              parity_q;
   logic [1:0]        stop_q;
   logic [31:0]       interval_q;

   logic              capture;
   logic              advance;
   logic              load_gap;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      state_next = state;
      dout_valid = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      capture    = 1'b0;
      advance    = 1'b0;
      load_gap   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               capture    = 1'b1;
               state_next = SEND;
            end
         end
         SEND: begin
            dout_valid = 1'b1;
            busy       = 1'b1;
            if (dout_ready) begin
               if (idx == LAST_IDX) begin
                  state_next = DONE;
               end else begin
                  advance = 1'b1;
                  if (GAP_CYCLES > 0) begin
                     load_gap   = 1'b1;
                     state_next = GAP;
                  end
               end
            end
         end
         GAP: begin
            busy = 1'b1;
            if (gap_cnt == GAP_W'(1)) state_next = SEND;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Byte-select mux; outside SEND the bus rests at zero.
   always_comb begin
      dout = 8'h00;
      if (state == SEND) begin
         case (idx)
            4'd0:    dout = HDR0;
            4'd1:    dout = HDR1;
            4'd2:    dout = HDR2;
            4'd3:    dout = parity_q ? PAR_EVEN : PAR_ODD;
            4'd4:    dout = stop_code(stop_q);
            4'd5:    dout = interval_q[31:24];
            4'd6:    dout = interval_q[23:16];
            4'd7:    dout = interval_q[15:8];
            4'd8:    dout = interval_q[7:0];
            default: dout = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge values, independent of statement order.
      if (rst) begin
         state      <= IDLE;
         idx        <= 4'd0;
         gap_cnt    <= '0;
         parity_q   <= 1'b0;
         stop_q     <= 2'b00;
         interval_q <= 32'h0;
      end else begin
         state <= state_next;
         if (capture) begin
            parity_q   <= parity_in;
            stop_q     <= stopbit_in;
            interval_q <= interval_in;
            idx        <= 4'd0;
         end else if (advance) begin
            idx <= idx + 4'd1;
         end
         if (load_gap) begin
            gap_cnt <= GAP_LOAD;
         end else if (state == GAP) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_config_framer.sv
// Bench for uart_config_framer: two instances (no gap, 3-cycle gap) checked every
// cycle against a frame-level model, plus hand-computed frame expectations.
module tb_uart_config_framer;

   localparam int GAP_A = 0;
   localparam int GAP_B = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        parity_in;
   logic [1:0]  stopbit_in;
   logic [31:0] interval_in;
   logic        dout_ready;
   logic [7:0]  dout       [2];
   logic        dout_valid [2];
   logic        busy       [2];
   logic        done       [2];

   always #5 clk = ~clk;

   uart_config_framer #(.GAP_CYCLES(GAP_A), .GAP_W(16)) dut_a (
      .clk(clk), .rst(rst), .start(start), .parity_in(parity_in),
      .stopbit_in(stopbit_in), .interval_in(interval_in),
      .dout(dout[0]), .dout_valid(dout_valid[0]), .dout_ready(dout_ready),
      .busy(busy[0]), .done(done[0])
   );

   uart_config_framer #(.GAP_CYCLES(GAP_B), .GAP_W(16)) dut_b (
      .clk(clk), .rst(rst), .start(start), .parity_in(parity_in),
      .stopbit_in(stopbit_in), .interval_in(interval_in),
      .dout(dout[1]), .dout_valid(dout_valid[1]), .dout_ready(dout_ready),
      .busy(busy[1]), .done(done[1])
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit checking = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   // Frame contents straight from the byte-order rules.
   function automatic logic [7:0] spec_byte(input int k, input logic p,
                                            input logic [1:0] s, input logic [31:0] iv);
      if (k < 3)  return 8'(8'hEE - 8'h11 * k);
      if (k == 3) return {7'b0, p};
      if (k == 4) return 8'(4 - int'(s));
      return 8'(iv >> (8 * (8 - k)));
   endfunction

   // Model: a frame is 9 bytes consumed one per handshake, with gap_of(d)
   // dead cycles after each non-final byte and one done cycle at the end.
   logic [7:0] mframe [2][9];
   int         mptr   [2];
   int         mgap   [2];
   bit         mact   [2];
   bit         mdone  [2];

   function automatic int gap_of(input int d);
      return (d == 0) ? GAP_A : GAP_B;
   endfunction

   initial begin
      for (int d = 0; d < 2; d++) begin
         mptr[d] = 0; mgap[d] = 0; mact[d] = 1'b0; mdone[d] = 1'b0;
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            mact[d] = 1'b0; mdone[d] = 1'b0; mgap[d] = 0; mptr[d] = 0;
         end else if (mdone[d]) begin
            mdone[d] = 1'b0;
         end else if (!mact[d]) begin
            if (start) begin
               for (int k = 0; k < 9; k++)
                  mframe[d][k] = spec_byte(k, parity_in, stopbit_in, interval_in);
               mptr[d] = 0; mgap[d] = 0; mact[d] = 1'b1;
            end
         end else if (mgap[d] > 0) begin
            mgap[d]--;
         end else if (dout_ready) begin
            mptr[d]++;
            if (mptr[d] == 9) begin
               mact[d] = 1'b0; mdone[d] = 1'b1;
            end else begin
               mgap[d] = gap_of(d);
            end
         end
      end
   end

   // Per-cycle compare plus logs of accepted bytes and done pulses.
   logic [7:0] acc_b0 [$];
   logic [7:0] acc_b1 [$];
   int         acc_c0 [$];
   int         acc_c1 [$];
   int         done_cnt [2];
   int         done_cyc [2];

   always @(negedge clk) begin
      if (checking) begin
         for (int d = 0; d < 2; d++) begin
            logic exp_valid;
            exp_valid = mact[d] && (mgap[d] == 0);
            check($sformatf("valid%0d", d), 32'(dout_valid[d]), 32'(exp_valid));
            if (exp_valid)
               check($sformatf("dout%0d[%0d]", d, mptr[d]), 32'(dout[d]), 32'(mframe[d][mptr[d]]));
            check($sformatf("busy%0d", d), 32'(busy[d]), 32'(mact[d]));
            check($sformatf("done%0d", d), 32'(done[d]), 32'(mdone[d]));
            if (done[d]) begin
               done_cnt[d]++;
               done_cyc[d] = cyc;
            end
         end
         if (dout_valid[0] && dout_ready) begin
            acc_b0.push_back(dout[0]); acc_c0.push_back(cyc);
         end
         if (dout_valid[1] && dout_ready) begin
            acc_b1.push_back(dout[1]); acc_c1.push_back(cyc);
         end
      end
   end

   task automatic cyc_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      acc_b0.delete(); acc_b1.delete(); acc_c0.delete(); acc_c1.delete();
      done_cnt[0] = 0; done_cnt[1] = 0;
      done_cyc[0] = -1; done_cyc[1] = -1;
   endtask

   task automatic pulse_start(input logic p, input logic [1:0] s,
                              input logic [31:0] iv, output int n);
      parity_in = p; stopbit_in = s; interval_in = iv;
      start = 1'b1;
      n = cyc;
      cyc_wait(1);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int max, input string name);
      for (int k = 0; k < max; k++) begin
         if (!mact[0] && !mdone[0] && !mact[1] && !mdone[1]) return;
         cyc_wait(1);
      end
      timeout(name);
   endtask

   initial begin
      int         n;
      logic [7:0] exp1 [9];
      logic [7:0] exp2 [9];
      logic [1:0] stops [4];
      logic [7:0] codes [4];
      logic       pat [4];

      exp1  = '{8'hEE, 8'hDD, 8'hCC, 8'h01, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
      exp2  = '{8'hEE, 8'hDD, 8'hCC, 8'h00, 8'h01, 8'hA5, 8'hC3, 8'h0F, 8'h96};
      stops = '{2'b11, 2'b10, 2'b01, 2'b00};
      codes = '{8'h01, 8'h02, 8'h03, 8'h04};
      pat   = '{1'b1, 1'b0, 1'b0, 1'b1};

      rst = 1'b1; start = 1'b0; dout_ready = 1'b0;
      parity_in = 1'b0; stopbit_in = 2'b00; interval_in = 32'h0;
      clear_logs();
      cyc_wait(2);
      checking = 1'b1;
      check("rst_dout",  32'(dout[0]),       32'h00);
      check("rst_valid", 32'(dout_valid[0]), 32'h0);
      check("rst_busy",  32'(busy[1]),       32'h0);
      check("rst_done",  32'(done[1]),       32'h0);
      rst = 1'b0;

      // Basic frame, both instances; instance B also shows the pacing.
      dout_ready = 1'b1;
      cyc_wait(1);
      clear_logs();
      pulse_start(1'b1, 2'b10, 32'h12345678, n);
      wait_idle(100, "basic_idle");
      check("basic_len", 32'(acc_b0.size()), 32'd9);
      for (int k = 0; k < 9; k++) check($sformatf("basic_b%0d", k), 32'(acc_b0[k]), 32'(exp1[k]));
      check("basic_first_cyc", 32'(acc_c0[0]), 32'(n + 1));
      check("basic_last_cyc",  32'(acc_c0[8]), 32'(n + 9));
      check("basic_done_cyc",  32'(done_cyc[0]), 32'(n + 10));
      check("pace_len", 32'(acc_b1.size()), 32'd9);
      for (int k = 0; k < 8; k++)
         check($sformatf("pace_gap%0d", k), 32'(acc_c1[k+1] - acc_c1[k]), 32'd4);
      check("pace_done_cyc", 32'(done_cyc[1]), 32'(acc_c1[8] + 1));
      check("pace_b8", 32'(acc_b1[8]), 32'h78);

      // Backpressure with ready cycling 1,0,0,1.
      clear_logs();
      pulse_start(1'b0, 2'b11, 32'hA5C30F96, n);
      for (int k = 0; k < 200; k++) begin
         if (!mact[0] && !mdone[0] && !mact[1] && !mdone[1]) break;
         dout_ready = pat[k % 4];
         cyc_wait(1);
      end
      dout_ready = 1'b1;
      wait_idle(100, "bp_idle");
      check("bp_len", 32'(acc_b0.size()), 32'd9);
      for (int k = 0; k < 9; k++) check($sformatf("bp_b%0d", k), 32'(acc_b0[k]), 32'(exp2[k]));
      check("bp_len_b", 32'(acc_b1.size()), 32'd9);

      // Field latch and ignored start mid-frame.
      clear_logs();
      pulse_start(1'b1, 2'b00, 32'hDEADBEEF, n);
      cyc_wait(2);
      interval_in = 32'h0; parity_in = 1'b0; stopbit_in = 2'b11;
      start = 1'b1;
      cyc_wait(1);
      start = 1'b0;
      wait_idle(100, "latch_idle");
      check("latch_par",  32'(acc_b0[3]), 32'h01);
      check("latch_stop", 32'(acc_b0[4]), 32'h04);
      check("latch_i3",   32'(acc_b0[5]), 32'hDE);
      check("latch_i2",   32'(acc_b0[6]), 32'hAD);
      check("latch_i1",   32'(acc_b0[7]), 32'hBE);
      check("latch_i0",   32'(acc_b0[8]), 32'hEF);
      check("latch_done_a", 32'(done_cnt[0]), 32'd1);
      check("latch_done_b", 32'(done_cnt[1]), 32'd1);
      cyc_wait(3);
      check("latch_no_requeue", 32'(dout_valid[0]), 32'h0);

      // Stop-code map.
      for (int j = 0; j < 4; j++) begin
         clear_logs();
         pulse_start(1'b0, stops[j], 32'h0, n);
         wait_idle(100, "stop_idle");
         check($sformatf("stop%0d_par", j),  32'(acc_b0[3]), 32'h00);
         check($sformatf("stop%0d_code", j), 32'(acc_b0[4]), 32'(codes[j]));
      end

      // Reset mid-frame after byte 4, then a fresh frame.
      clear_logs();
      pulse_start(1'b1, 2'b01, 32'h0BADF00D, n);
      for (int k = 0; k < 50 && acc_b0.size() < 5; k++) cyc_wait(1);
      if (acc_b0.size() < 5) timeout("abort_wait");
      rst = 1'b1;
      cyc_wait(1);
      rst = 1'b0;
      @(negedge clk);
      check("abort_valid_a", 32'(dout_valid[0]), 32'h0);
      check("abort_busy_a",  32'(busy[0]),       32'h0);
      check("abort_valid_b", 32'(dout_valid[1]), 32'h0);
      check("abort_busy_b",  32'(busy[1]),       32'h0);
      @(posedge clk); #1;
      cyc_wait(5);
      check("abort_no_done_a", 32'(done_cnt[0]), 32'd0);
      check("abort_no_done_b", 32'(done_cnt[1]), 32'd0);
      clear_logs();
      pulse_start(1'b1, 2'b01, 32'h0BADF00D, n);
      wait_idle(100, "fresh_idle");
      check("fresh_len", 32'(acc_b0.size()), 32'd9);
      check("fresh_b0",  32'(acc_b0[0]), 32'hEE);
      check("fresh_b4",  32'(acc_b0[4]), 32'h03);
      check("fresh_b8",  32'(acc_b0[8]), 32'h0D);
      check("fresh_done", 32'(done_cnt[0]), 32'd1);

      // Start coincident with reset: reset wins.
      rst = 1'b1; start = 1'b1;
      cyc_wait(1);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("rst_start_valid", 32'(dout_valid[0]), 32'h0);
      check("rst_start_busy",  32'(busy[1]),       32'h0);
      @(posedge clk); #1;
      cyc_wait(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
